// File: rtl/led_nibble_pkg.sv
// Shared types and constants for the LED nibble capture path.
package led_nibble_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned NUM_NIBBLES = 4;
    localparam int unsigned WORD_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SLOT,
        DONE
    } cap_state_e;

    typedef logic [$clog2(NUM_NIBBLES)-1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_NIBBLES - 1);

endpackage

// File: rtl/led_nibble_capture_sync_ff.sv
// Reset-to-zero multi-flop synchronizer for a bus of asynchronous inputs.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/led_nibble_capture.sv
// Receive side of the LED nibble display link: rebuilds a 16-bit word from the
// nibble-serial stream. Optional macro NIBBLE_CAPTURE_CONFIRM_EN requires two matching frames.
module led_nibble_capture
    import led_nibble_pkg::*;
#(
    parameter int unsigned NIBBLE_CYCLES = 6000000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  nib_in,
    input  logic        pos_in,
    output logic [15:0] value,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(NIBBLE_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(NIBBLE_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(NIBBLE_CYCLES - 1);

    logic [NIBBLE_W:0]   sync_q;
    logic                pos_s;
    logic [NIBBLE_W-1:0] nib_s;
    logic                pos_d;
    logic                pos_rise;

    cap_state_e          state, state_nx;
    logic [CNT_W-1:0]    cnt;
    slot_t               slot;
    logic [WORD_W-1:0]   sr;

    logic cnt_clr, cnt_inc, slot_clr, slot_inc, shift_en, err_d, done;

`ifdef NIBBLE_CAPTURE_CONFIRM_EN
    logic [WORD_W-1:0] cand;
    logic              cand_v;
`endif

    sync_ff #(
        .WIDTH  (NIBBLE_W + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({pos_in, nib_in}),
        .q     (sync_q)
    );

    assign pos_s    = sync_q[NIBBLE_W];
    assign nib_s    = sync_q[NIBBLE_W-1:0];
    assign pos_rise = pos_s & ~pos_d;
    assign busy     = (state == ALIGN) || (state == SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        slot_clr = 1'b0;
        slot_inc = 1'b0;
        shift_en = 1'b0;
        err_d    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pos_rise) begin
                    cnt_clr  = 1'b1;
                    slot_clr = 1'b1;
                    state_nx = ALIGN;
                end
            end
            ALIGN: begin
                // A marker that has already dropped at mid-slot was a glitch
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    if (pos_s) begin
                        shift_en = 1'b1;
                        slot_inc = 1'b1;
                        state_nx = SLOT;
                    end else begin
                        err_d    = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SLOT: begin
                if (cnt == SLOT_LAST) begin
                    cnt_clr = 1'b1;
                    if (pos_s) begin
                        err_d    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        shift_en = 1'b1;
                        if (slot == LAST_SLOT) begin
                            state_nx = DONE;
                        end else begin
                            slot_inc = 1'b1;
                        end
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_d     <= 1'b0;
            cnt       <= '0;
            slot      <= '0;
            sr        <= '0;
            value     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef NIBBLE_CAPTURE_CONFIRM_EN
            cand      <= '0;
            cand_v    <= 1'b0;
`endif
        end else begin
            pos_d     <= pos_s;
            valid     <= 1'b0;
            frame_err <= err_d;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (slot_clr) begin
                slot <= '0;
            end else if (slot_inc) begin
                slot <= slot + slot_t'(1);
            end

            if (shift_en) begin
                sr <= {sr[WORD_W-NIBBLE_W-1:0], nib_s};
            end

`ifdef NIBBLE_CAPTURE_CONFIRM_EN
            if (err_d) begin
                cand_v <= 1'b0;
            end
            // Publish only when this frame repeats the previous error-free one
            if (done) begin
                if (cand_v && (cand == sr)) begin
                    value <= sr;
                    valid <= 1'b1;
                end else begin
                    cand   <= sr;
                    cand_v <= 1'b1;
                end
            end
`else
            if (done) begin
                value <= sr;
                valid <= 1'b1;
            end
`endif
        end
    end

endmodule
